lcd_seq_ctrl: RTL and testbench
===============================

LCD_SEQ_CTRL -- requirements
Module: lcd_seq_ctrl

Interface
REQ-001 SHALL have parameter SETUP_CYC, default 2: cycles from RS/data valid to E rise.
REQ-002 SHALL have parameter E_HIGH_CYC, default 12: cycles E is held high.
REQ-003 SHALL have parameter HOLD_CYC, default 2: cycles data/RS are held after E falls.
REQ-004 SHALL have parameter WAIT_CYC, default 2000: post-command busy wait in cycles.
REQ-005 SHALL have parameter CLR_WAIT_CYC, default 82000: post-command wait for commands 0x01 and 0x02 with RS=0.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port address, input, 3: Avalon-MM register select.
REQ-009 SHALL have port chipselect, input, 1: slave select.
REQ-010 SHALL have port write_n, input, 1: active-low write strobe.
REQ-011 SHALL have port writedata, input, 32: write data.
REQ-012 SHALL have port readdata, output, 32: combinational, zero-latency read data.
REQ-013 SHALL have port lcd_data, output, 8: LCD data bus.
REQ-014 SHALL have ports lcd_rs, lcd_rw and lcd_e, each output, 1: register select, read/write and enable strobe.

Function
REQ-015 SHALL decode a write as chipselect && !write_n.
REQ-016 SHALL push {writedata[8], writedata[7:0]} (rs, data) into a 4-entry FIFO on a write to address 0 when the FIFO is not full.
REQ-017 SHALL drop a write to address 0 when the FIFO is full, and SHALL set the sticky ovf bit.
REQ-018 SHALL clear ovf on any write to address 1.
REQ-019 SHALL return {ovf[7], full[6], empty[5], count[4:2], busy[0]} on address 1, zero elsewhere on bits 31:8 and bit 1, and zero for unmapped addresses.
REQ-020 SHALL use FSM states IDLE, SETUP, EHI, HOLD and WAIT.
REQ-021 In IDLE with the FIFO non-empty, SHALL pop the head, latch lcd_rs/lcd_data on the next edge and enter SETUP.
REQ-022 SHALL spend exactly SETUP_CYC, E_HIGH_CYC, HOLD_CYC and then WAIT_CYC (or CLR_WAIT_CYC) cycles in SETUP, EHI, HOLD and WAIT respectively, then return to IDLE.
REQ-023 SHALL drive lcd_e high only in EHI.
REQ-024 SHALL keep lcd_data and lcd_rs stable from SETUP through the end of HOLD.
REQ-025 SHALL tie lcd_rw to 0; the block is write-only.
REQ-026 SHALL assert busy whenever state != IDLE or the FIFO is non-empty.
REQ-027 SHALL make a push and a pop in the same cycle leave count unchanged, and the pushed entry SHALL be served later in order.
REQ-028 SHALL use a 20-bit down-counter loaded with (N-1) on state entry and advance when it reaches 0.
REQ-029 SHALL treat an entry of 0 in SETUP_CYC, E_HIGH_CYC or HOLD_CYC as 1 cycle.

Reset
REQ-030 SHALL, on reset_n low, asynchronously set state=IDLE, FIFO empty, count=0, ovf=0, lcd_data=0, lcd_rs=0, lcd_e=0 and counter=0.
REQ-031 SHALL, on reset asserted mid-command, drop lcd_e low immediately, discard queued entries, and not resume the command after release.

Configuration
REQ-032 SHALL compile in the interrupt feature when macro LCD_SEQ_IRQ_EN is defined.
REQ-033 With LCD_SEQ_IRQ_EN, SHALL add output irq, 1, and SHALL make address 2 bit 0 a read/write irq-enable, reset 0.
REQ-034 With LCD_SEQ_IRQ_EN, SHALL set a sticky done flag when the FSM enters IDLE from WAIT with the FIFO empty, and SHALL clear it on any write to address 3.
REQ-035 With LCD_SEQ_IRQ_EN, SHALL drive irq = done && enable, and SHALL report done on status bit 1.
REQ-036 Without LCD_SEQ_IRQ_EN, SHALL have no irq port, SHALL ignore writes to addresses 2 and 3, SHALL read them as 0, and SHALL read status bit 1 as 0.

Verification
REQ-037 SHALL verify: write 0x138 to addr 0 with defaults -> lcd_rs=1, lcd_data=0x38, lcd_e high for exactly 12 cycles, busy low 2016 cycles after the pop.
REQ-038 SHALL verify: write 0x001 -> WAIT lasts 82000 cycles; write 0x003 -> WAIT lasts 2000 cycles.
REQ-039 SHALL verify: 5 writes back-to-back while busy -> fifth dropped, status reads 0xC0|count field=4|busy, then write addr 1 -> ovf=0.
REQ-040 SHALL verify: push coinciding with a pop at count=4 -> accepted, no ovf, commands emitted in write order.
REQ-041 SHALL verify: reset_n low during EHI -> lcd_e=0 within the same cycle, status reads 0x20 after release.
REQ-042 SHALL verify, with LCD_SEQ_IRQ_EN: enable=1, one command -> irq rises on IDLE entry; write addr 3 -> irq=0.

Source files
------------

// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: Avalon-MM 4-entry command FIFO driving a timed LCD write strobe sequencer.
// Define LCD_SEQ_IRQ_EN to add the done flag, irq-enable register and irq output.
module lcd_seq_ctrl #(
    parameter int SETUP_CYC    = 2,
    parameter int E_HIGH_CYC   = 12,
    parameter int HOLD_CYC     = 2,
    parameter int WAIT_CYC     = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
`ifdef LCD_SEQ_IRQ_EN
    output logic        lcd_e,
    output logic        irq
`else
    output logic        lcd_e
`endif
);
    localparam logic [19:0] SETUP_LD = (SETUP_CYC > 1) ? 20'(SETUP_CYC - 1) : 20'd0;
    localparam logic [19:0] EHI_LD   = (E_HIGH_CYC > 1) ? 20'(E_HIGH_CYC - 1) : 20'd0;
    localparam logic [19:0] HOLD_LD  = (HOLD_CYC > 1) ? 20'(HOLD_CYC - 1) : 20'd0;
    localparam logic [19:0] WAIT_LD  = (WAIT_CYC > 1) ? 20'(WAIT_CYC - 1) : 20'd0;
    localparam logic [19:0] CLR_LD   = (CLR_WAIT_CYC > 1) ? 20'(CLR_WAIT_CYC - 1) : 20'd0;

    typedef enum logic [2:0] {IDLE, SETUP, EHI, HOLD, WAIT} state_t;

    state_t      state;
    logic [19:0] cnt;
    logic [8:0]  fifo [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  count;
    logic        ovf, wr, empty, full, pop, push, clr_cmd, busy;
    logic        done, irq_en;

    assign wr      = chipselect && !write_n;
    assign empty   = count == 3'd0;
    assign full    = count[2];
    assign pop     = state == IDLE && !empty;
    assign push    = wr && address == 3'd0 && (!full || pop);
    assign busy    = state != IDLE || !empty;
    assign clr_cmd = !lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02);
    assign lcd_rw  = 1'b0;

    // FIFO storage; only valid entries are ever read, so no reset is needed
    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= writedata[8:0];

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            ovf    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, push} - {2'b0, pop};
            if (wr && address == 3'd1) ovf <= 1'b0;
            else if (wr && address == 3'd0 && !push) ovf <= 1'b1;
        end

    // Command sequencer: each phase loads cnt with its length minus one and advances at zero
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 20'd0;
            lcd_data <= 8'd0;
            lcd_rs   <= 1'b0;
            lcd_e    <= 1'b0;
        end else begin
            case (state)
                IDLE:
                    if (!empty) begin
                        state              <= SETUP;
                        cnt                <= SETUP_LD;
                        {lcd_rs, lcd_data} <= fifo[rd_ptr];
                    end
                SETUP:
                    if (cnt == 20'd0) begin
                        state <= EHI;
                        cnt   <= EHI_LD;
                        lcd_e <= 1'b1;
                    end else cnt <= cnt - 20'd1;
                EHI:
                    if (cnt == 20'd0) begin
                        state <= HOLD;
                        cnt   <= HOLD_LD;
                        lcd_e <= 1'b0;
                    end else cnt <= cnt - 20'd1;
                HOLD:
                    if (cnt == 20'd0) begin
                        state <= WAIT;
                        cnt   <= clr_cmd ? CLR_LD : WAIT_LD;
                    end else cnt <= cnt - 20'd1;
                default:
                    if (cnt == 20'd0) state <= IDLE;
                    else cnt <= cnt - 20'd1;
            endcase
        end

`ifdef LCD_SEQ_IRQ_EN
    // Done is raised when the last queued command finishes its wait; cleared by a write to address 3
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            done   <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (wr && address == 3'd2) irq_en <= writedata[0];
            if (wr && address == 3'd3) done <= 1'b0;
            else if (state == WAIT && cnt == 20'd0 && empty && !push) done <= 1'b1;
        end

    assign irq = done && irq_en;
`else
    assign done   = 1'b0;
    assign irq_en = 1'b0;
`endif

    // Zero-latency register read mux
    always_comb
        readdata = address == 3'd1 ? {24'd0, ovf, full, empty, count, done, busy} :
                   address == 3'd2 ? {31'd0, irq_en} : 32'd0;
endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// tb_lcd_seq_ctrl: queue/timeline model of the LCD sequencer checked every cycle plus directed literal checks.
// Build with LCD_SEQ_IRQ_EN defined to exercise the interrupt registers.
module tb_lcd_seq_ctrl;
    localparam int S  = 2;
    localparam int E  = 12;
    localparam int H  = 2;
    localparam int W  = 100;
    localparam int CW = 500;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd1;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_e;
    logic        cs2 = 1'b0;
    logic [31:0] rd2;
    logic [7:0]  d2;
    logic        rs2, rw2, e2;
`ifdef LCD_SEQ_IRQ_EN
    logic        irq, irq2;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lcd_seq_ctrl #(.SETUP_CYC(S), .E_HIGH_CYC(E), .HOLD_CYC(H), .WAIT_CYC(W), .CLR_WAIT_CYC(CW)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
`ifdef LCD_SEQ_IRQ_EN
        .irq(irq),
`endif
        .lcd_e(lcd_e)
    );

    lcd_seq_ctrl #(.SETUP_CYC(0), .E_HIGH_CYC(0), .HOLD_CYC(0), .WAIT_CYC(3), .CLR_WAIT_CYC(5)) dut_zero (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2), .write_n(write_n),
        .writedata(writedata), .readdata(rd2), .lcd_data(d2), .lcd_rs(rs2), .lcd_rw(rw2),
`ifdef LCD_SEQ_IRQ_EN
        .irq(irq2),
`endif
        .lcd_e(e2)
    );

    logic [8:0] mq[$];
    logic [8:0] cur = 9'd0;
    bit act = 0, ovf_m = 0, done_m = 0, en_m = 0;
    bit m_wr, m_pop, m_acc;
    int el = 0, tot = 0;

    function automatic int dur(input logic [8:0] c);
        return S + E + H + ((!c[8] && (c[7:0] == 8'h01 || c[7:0] == 8'h02)) ? CW : W);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            cur = 9'd0; act = 0; ovf_m = 0; done_m = 0; en_m = 0; el = 0; tot = 0;
        end else begin
            m_wr  = chipselect && !write_n;
            m_pop = !act && mq.size() > 0;
            m_acc = m_wr && address == 3'd0 && (mq.size() < 4 || m_pop);
            if (m_pop) begin
                cur = mq.pop_front();
                act = 1; el = 0; tot = dur(cur);
            end else if (act) begin
                el++;
                if (el == tot) begin
                    act = 0;
                    if (mq.size() == 0 && !m_acc) done_m = 1;
                end
            end
            if (m_acc) mq.push_back(writedata[8:0]);
            if (m_wr && address == 3'd1) ovf_m = 0;
            else if (m_wr && address == 3'd0 && !m_acc) ovf_m = 1;
            if (m_wr && address == 3'd2) en_m = writedata[0];
            if (m_wr && address == 3'd3) done_m = 0;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        logic [7:0] st;
        logic d, en;
`ifdef LCD_SEQ_IRQ_EN
        d = done_m; en = en_m;
`else
        d = 1'b0; en = 1'b0;
`endif
        st = {ovf_m, mq.size() == 4, mq.size() == 0, 3'(mq.size()), d, act || mq.size() != 0};
        return a == 3'd1 ? {24'd0, st} : (a == 3'd2 ? {31'd0, en} : 32'd0);
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("m_lcd_e", {31'd0, lcd_e}, {31'd0, act && el >= S && el < S + E});
        chk("m_lcd_bus", {23'd0, lcd_rs, lcd_data}, {23'd0, cur});
        chk("m_lcd_rw", {31'd0, lcd_rw}, 32'd0);
        chk("m_readdata", readdata, exp_rd(address));
`ifdef LCD_SEQ_IRQ_EN
        chk("m_irq", {31'd0, irq}, {31'd0, done_m && en_m});
`endif
    end

    int e_run = 0, e_len = 0;
    logic e_q = 1'b0;
    logic [8:0] seen[$];
    always @(negedge clk) begin
        if (lcd_e && !e_q) seen.push_back({lcd_rs, lcd_data});
        if (lcd_e) e_run++;
        else if (e_run != 0) begin
            e_len = e_run;
            e_run = 0;
        end
        e_q = lcd_e;
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1; address = 3'd1;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (!readdata[0]) break;
            n++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n, e2n;
        logic [8:0] cmd_tab [5];
        int bsy_tab [5];
        logic [8:0] ord_tab [6];
        cmd_tab = '{9'h138, 9'h001, 9'h002, 9'h003, 9'h101};
        bsy_tab = '{1 + S + E + H + W, 1 + S + E + H + CW, 1 + S + E + H + CW, 1 + S + E + H + W, 1 + S + E + H + W};
        ord_tab = '{9'h141, 9'h142, 9'h143, 9'h144, 9'h145, 9'h147};
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("reset_status", readdata, 32'h20);
        chk("reset_e", {31'd0, lcd_e}, 32'd0);
        chk("reset_bus", {23'd0, lcd_rs, lcd_data}, 32'd0);
        @(posedge clk); #1;
        chk("busy_117_literal", 32'(bsy_tab[0]), 32'd117);
        chk("busy_517_literal", 32'(bsy_tab[1]), 32'd517);
        for (int i = 0; i < 5; i++) begin
            wr(3'd0, {23'd0, cmd_tab[i]});
            busy_len(n);
            chk("busy_cycles", 32'(n), 32'(bsy_tab[i]));
            chk("e_width", 32'(e_len), 32'd12);
            chk("latched_cmd", {23'd0, lcd_rs, lcd_data}, {23'd0, cmd_tab[i]});
        end
        seen.delete();
        wr(3'd0, 32'h141);
        for (int i = 2; i <= 6; i++) wr(3'd0, 32'h140 + 32'(i));
        @(negedge clk);
        chk("ovf_status", readdata, 32'hD1);
        @(posedge clk); #1;
        wr(3'd1, 32'd0);
        @(negedge clk);
        chk("ovf_cleared", readdata, 32'h51);
        @(posedge clk); #1;
        n = 0;
        while (!(!act && mq.size() == 4) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_full_idle", {31'd0, !act && mq.size() == 4}, 32'd1);
        wr(3'd0, 32'h147);
        @(negedge clk);
        chk("coincide_status", readdata, 32'h51);
        @(posedge clk); #1;
        busy_len(n);
        chk("drain_done", {31'd0, readdata[0]}, 32'd0);
        chk("order_count", 32'(seen.size()), 32'd6);
        for (int i = 0; i < 6 && i < seen.size(); i++) chk("order", {23'd0, seen[i]}, {23'd0, ord_tab[i]});
`ifdef LCD_SEQ_IRQ_EN
        wr(3'd2, 32'd1);
        address = 3'd2;
        @(negedge clk);
        chk("irq_en_read", readdata, 32'd1);
        @(posedge clk); #1;
        address = 3'd1;
        wr(3'd3, 32'd0);
        @(negedge clk);
        chk("irq_cleared_pre", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        wr(3'd0, 32'h105);
        busy_len(n);
        chk("irq_raised", {31'd0, irq}, 32'd1);
        chk("done_status", readdata & 32'h2, 32'h2);
        wr(3'd3, 32'd0);
        @(negedge clk);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
`else
        wr(3'd2, 32'd1);
        wr(3'd3, 32'd1);
        address = 3'd2;
        @(negedge clk);
        chk("addr2_zero", readdata, 32'd0);
        @(posedge clk); #1;
        address = 3'd3;
        @(negedge clk);
        chk("addr3_zero", readdata, 32'd0);
        @(posedge clk); #1;
        address = 3'd1;
`endif
        address = 3'd5;
        @(negedge clk);
        chk("addr5_zero", readdata, 32'd0);
        @(posedge clk); #1;
        address = 3'd1;
        wr(3'd0, 32'h138);
        wr(3'd0, 32'h155);
        wr(3'd0, 32'h166);
        n = 0;
        while (!lcd_e && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("e_seen", {31'd0, lcd_e}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("reset_e_async", {31'd0, lcd_e}, 32'd0);
        chk("reset_status_async", readdata, 32'h20);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_status", readdata, 32'h20);
        @(posedge clk); #1;
        busy_len(n);
        chk("no_resume", 32'(n), 32'd0);
        chk("no_resume_bus", {23'd0, lcd_rs, lcd_data}, 32'd0);
        cs2 = 1'b1; write_n = 1'b0; address = 3'd0; writedata = 32'h141;
        @(posedge clk); #1;
        cs2 = 1'b0; write_n = 1'b1; address = 3'd1;
        n = 0; e2n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!rd2[0]) break;
            n++;
            if (e2) e2n++;
        end
        chk("zero_param_busy", 32'(n), 32'd7);
        chk("zero_param_e", 32'(e2n), 32'd1);
        chk("zero_param_bus", {23'd0, rs2, d2}, 32'h141);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
